// File: rtl/friscv_mem_arbiter_if.sv
// Bus bundle between the rv32i core's fetch/data ports, the arbiter and a
// single-port memory. The master view belongs to the arbiter, which masters
// the memory side; the slave view belongs to the surrounding core and memory.
interface friscv_mem_arbiter_if #(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
);

  // Fetch port
  logic               inst_en;
  logic [ADDRW-1:0]   inst_addr;
  logic [XLEN-1:0]    inst_rdata;
  logic               inst_ready;

  // Data port
  logic               data_en;
  logic               data_wr;
  logic [ADDRW-1:0]   data_addr;
  logic [XLEN-1:0]    data_wdata;
  logic [XLEN/8-1:0]  data_strb;
  logic [XLEN-1:0]    data_rdata;
  logic               data_ready;

  // Memory port
  logic               mem_en;
  logic               mem_wr;
  logic [ADDRW-1:0]   mem_addr;
  logic [XLEN-1:0]    mem_wdata;
  logic [XLEN/8-1:0]  mem_strb;
  logic [XLEN-1:0]    mem_rdata;
  logic               mem_ready;

  modport master (
    input  inst_en, inst_addr,
    output inst_rdata, inst_ready,
    input  data_en, data_wr, data_addr, data_wdata, data_strb,
    output data_rdata, data_ready,
    output mem_en, mem_wr, mem_addr, mem_wdata, mem_strb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output inst_en, inst_addr,
    input  inst_rdata, inst_ready,
    output data_en, data_wr, data_addr, data_wdata, data_strb,
    input  data_rdata, data_ready,
    input  mem_en, mem_wr, mem_addr, mem_wdata, mem_strb,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/friscv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the rv32i
// instruction-fetch and data ports. Completion hands the grant straight to a
// waiting peer without an idle cycle; a watchdog flags accesses that stall.
module friscv_mem_arbiter #(
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   aclk,
  input  logic                   srst,
  friscv_mem_arbiter_if.master   bus,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // Counter wide enough to hold TIMEOUT; saturates there so it never wraps.
  localparam int CNTW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(TIMEOUT);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             state;
  state_t             state_next;
  port_t              last_grant;
  logic [CNTW-1:0]    wait_cnt;
  logic               waiting;

  logic               mem_en_c;
  logic               mem_wr_c;
  logic [ADDRW-1:0]   addr_mux;
  logic [XLEN-1:0]    wdata_mux;
  logic [XLEN/8-1:0]  strb_mux;

  // State register and round-robin history; last_grant records who completed.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state      <= IDLE;
      last_grant <= PORT_D;
    end else begin
      state <= state_next;
      if (bus.mem_ready && state == GNT_I) begin
        last_grant <= PORT_I;
      end else if (bus.mem_ready && state == GNT_D) begin
        last_grant <= PORT_D;
      end
    end
  end

  // Next-state: arbitrate from IDLE, hand over to the peer on completion.
  // The completing port's own en is ignored on its ready cycle.
  // NOTE: state_next gets a default first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.inst_en && bus.data_en) begin
          state_next = (last_grant == PORT_D) ? GNT_I : GNT_D;
        end else if (bus.inst_en) begin
          state_next = GNT_I;
        end else if (bus.data_en) begin
          state_next = GNT_D;
        end
      end
      GNT_I: begin
        if (bus.mem_ready) begin
          state_next = bus.data_en ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        if (bus.mem_ready) begin
          state_next = bus.inst_en ? GNT_I : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory request mux: fetch accesses are always reads with zero strobes.
  always_comb begin
    mem_en_c  = 1'b0;
    mem_wr_c  = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    strb_mux  = '0;
    unique case (state)
      GNT_I: begin
        mem_en_c = 1'b1;
        addr_mux = bus.inst_addr;
      end
      GNT_D: begin
        mem_en_c  = 1'b1;
        mem_wr_c  = bus.data_wr;
        addr_mux  = bus.data_addr;
        wdata_mux = bus.data_wdata;
        strb_mux  = bus.data_strb;
      end
      default: ;
    endcase
  end

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_wr    = mem_wr_c;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_strb  = strb_mux;

  // Read data is shared; only the granted port sees a ready pulse.
  assign bus.inst_rdata = bus.mem_rdata;
  assign bus.data_rdata = bus.mem_rdata;
  assign bus.inst_ready = bus.mem_ready && (state == GNT_I);
  assign bus.data_ready = bus.mem_ready && (state == GNT_D);

  assign waiting = (state != IDLE) && !bus.mem_ready;

  // Watchdog: counts stalled grant cycles; err is sticky and never aborts.
  always_ff @(posedge aclk) begin
    if (srst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state_next != state || bus.mem_ready) begin
        wait_cnt <= '0;
      end else if (waiting && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CNTW'(1);
      end
      if (TIMEOUT != 0 && waiting && wait_cnt == CNT_LAST) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_friscv_mem_arbiter.sv
// Testbench for friscv_mem_arbiter: directed cycle checks for reset,
// handover, fairness, stray ready and watchdog, then a randomized phase where
// both ports hammer a behavioural memory and a scoreboard checks every ready.
module tb_friscv_mem_arbiter;

  localparam int ADDRW   = 16;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;

  logic aclk = 1'b0;
  logic srst = 1'b1;
  logic err;

  always #5 aclk = ~aclk;

  friscv_mem_arbiter_if #(.ADDRW(ADDRW), .XLEN(XLEN)) bus ();

  friscv_mem_arbiter #(.ADDRW(ADDRW), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .aclk (aclk),
    .srst (srst),
    .bus  (bus),
    .err  (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct packed {
    logic        is_read;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_inst_q[$];
  exp_t        exp_data_q[$];
  logic [31:0] ref_mem [logic [15:0]];
  logic [31:0] dev_mem [logic [15:0]];

  bit          mem_auto  = 1'b0;
  bit          sb_en     = 1'b0;
  logic        man_ready = 1'b0;
  logic [31:0] man_rdata = '0;

  function automatic logic [31:0] init_val(input logic [15:0] a);
    return 32'hA5C3_0000 ^ ({16'h0, a} * 32'h9E37_79B1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic smp();
    @(negedge aclk);
  endtask

  // Memory device: manual mode mirrors man_ready/man_rdata; auto mode answers
  // each new request after 0..3 extra cycles and checks the request and the
  // ready routing against whichever requester it must have come from.
  initial begin
    bit          busy;
    int          wait_left;
    int          port;
    logic [15:0] a;
    busy          = 1'b0;
    wait_left     = 0;
    port          = 2;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge aclk);
      #2;
      if (!mem_auto) begin
        busy          = 1'b0;
        bus.mem_ready = man_ready;
        bus.mem_rdata = man_rdata;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        if (!bus.mem_en) begin
          busy = 1'b0;
        end else begin
          if (!busy) begin
            busy      = 1'b1;
            wait_left = $urandom_range(0, 3);
            if (bus.inst_en && bus.mem_addr == bus.inst_addr && !bus.mem_wr &&
                bus.mem_strb == 4'h0 && bus.mem_wdata == 32'h0) begin
              port = 0;
            end else if (bus.data_en && bus.mem_addr == bus.data_addr &&
                         bus.mem_wr == bus.data_wr && bus.mem_strb == bus.data_strb &&
                         bus.mem_wdata == bus.data_wdata) begin
              port = 1;
            end else begin
              port = 2;
            end
            check("mem_req_matches_a_port", (port != 2), 1);
          end
          if (wait_left == 0) begin
            a             = bus.mem_addr;
            bus.mem_ready = 1'b1;
            bus.mem_rdata = dev_mem.exists(a) ? dev_mem[a] : init_val(a);
            if (bus.mem_wr) dev_mem[a] = merge(bus.mem_rdata, bus.mem_wdata, bus.mem_strb);
            busy = 1'b0;
            @(negedge aclk);
            check("ready_route_inst", bus.inst_ready, (port == 0));
            check("ready_route_data", bus.data_ready, (port == 1));
          end else begin
            wait_left--;
          end
        end
      end
    end
  end

  // Scoreboard monitor: pops one expectation per ready pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (sb_en && bus.inst_ready) begin
        if (exp_inst_q.size() == 0) begin
          check("inst_ready_unexpected", 1, 0);
        end else begin
          e = exp_inst_q.pop_front();
          check("inst_rdata", bus.inst_rdata, e.rdata);
        end
      end
      if (sb_en && bus.data_ready) begin
        if (exp_data_q.size() == 0) begin
          check("data_ready_unexpected", 1, 0);
        end else begin
          e = exp_data_q.pop_front();
          if (e.is_read) check("data_rdata", bus.data_rdata, e.rdata);
        end
      end
    end
  end

  task automatic fetch_driver(input int n);
    bit seen;
    int budget;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) cyc();
      bus.inst_addr = 16'($urandom_range(0, 255));
      bus.inst_en   = 1'b1;
      exp_inst_q.push_back('{1'b1, init_val(bus.inst_addr)});
      seen   = 1'b0;
      budget = 0;
      while (!seen && budget < 40) begin
        @(negedge aclk);
        seen = bus.inst_ready;
        budget++;
      end
      check("fetch_done_in_budget", seen, 1);
      cyc();
      bus.inst_en = 1'b0;
    end
  endtask

  task automatic data_driver(input int n);
    bit          seen;
    int          budget;
    logic [15:0] a;
    logic [31:0] old;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) cyc();
      a              = 16'h0100 + 16'($urandom_range(0, 15));
      bus.data_addr  = a;
      bus.data_wr    = 1'($urandom_range(0, 1));
      bus.data_wdata = $urandom;
      bus.data_strb  = 4'($urandom_range(0, 15));
      bus.data_en    = 1'b1;
      old = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
      if (bus.data_wr) begin
        ref_mem[a] = merge(old, bus.data_wdata, bus.data_strb);
        exp_data_q.push_back('{1'b0, 32'h0});
      end else begin
        exp_data_q.push_back('{1'b1, old});
      end
      seen   = 1'b0;
      budget = 0;
      while (!seen && budget < 40) begin
        @(negedge aclk);
        seen = bus.data_ready;
        budget++;
      end
      check("data_done_in_budget", seen, 1);
      cyc();
      bus.data_en = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "global timeout");
  end

  initial begin
    int n_i;
    int n_d;
    bit exp_i;

    bus.inst_en    = 1'b0;
    bus.inst_addr  = '0;
    bus.data_en    = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    bus.data_strb  = '0;
    srst           = 1'b1;

    // Reset state
    repeat (2) cyc();
    srst = 1'b0;
    smp();
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_inst_ready", bus.inst_ready, 0);
    check("rst_data_ready", bus.data_ready, 0);
    check("rst_err", err, 0);

    // Reset mid-GNT_D with mem_ready held low
    cyc();
    bus.data_en = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 16'h0120;
    cyc(); smp();
    check("midrst_pre_mem_en", bus.mem_en, 1);
    check("midrst_pre_addr", bus.mem_addr, 16'h0120);
    cyc();
    srst = 1'b1;
    cyc();
    srst = 1'b0; bus.data_en = 1'b0;
    smp();
    check("midrst_mem_en", bus.mem_en, 0);
    check("midrst_data_ready", bus.data_ready, 0);
    check("midrst_err", err, 0);

    // Single fetch, memory answers on the second grant cycle
    cyc();
    bus.inst_en = 1'b1; bus.inst_addr = 16'h0010;
    cyc(); smp();
    check("fetch_mem_en", bus.mem_en, 1);
    check("fetch_mem_addr", bus.mem_addr, 16'h0010);
    check("fetch_mem_wr", bus.mem_wr, 0);
    check("fetch_no_early_ready", bus.inst_ready, 0);
    cyc();
    man_ready = 1'b1; man_rdata = 32'h0050_0093;
    smp();
    check("fetch_inst_ready", bus.inst_ready, 1);
    check("fetch_inst_rdata", bus.inst_rdata, 32'h0050_0093);
    check("fetch_data_ready", bus.data_ready, 0);
    cyc();
    man_ready = 1'b0; man_rdata = '0; bus.inst_en = 1'b0;
    smp();
    check("fetch_ready_once", bus.inst_ready, 0);
    check("fetch_back_idle", bus.mem_en, 0);

    // Simultaneous requests right after reset: fetch first, then data
    cyc(); srst = 1'b1;
    cyc(); srst = 1'b0;
    bus.inst_en = 1'b1; bus.inst_addr = 16'h0020;
    bus.data_en = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 16'h0100;
    bus.data_strb = 4'hF; bus.data_wdata = 32'hDEAD_BEEF;
    cyc();
    man_ready = 1'b1; man_rdata = 32'h0000_1111;
    smp();
    check("sim_first_addr", bus.mem_addr, 16'h0020);
    check("sim_first_wr", bus.mem_wr, 0);
    check("sim_first_strb", bus.mem_strb, 4'h0);
    check("sim_first_wdata", bus.mem_wdata, 32'h0);
    check("sim_first_inst_ready", bus.inst_ready, 1);
    check("sim_first_data_ready", bus.data_ready, 0);
    cyc();
    man_ready = 1'b0; bus.inst_en = 1'b0;
    smp();
    check("sim_no_bubble", bus.mem_en, 1);
    check("sim_second_wr", bus.mem_wr, 1);
    check("sim_second_addr", bus.mem_addr, 16'h0100);
    check("sim_second_strb", bus.mem_strb, 4'hF);
    check("sim_second_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("sim_second_wait", bus.data_ready, 0);
    cyc();
    man_ready = 1'b1;
    smp();
    check("sim_data_ready", bus.data_ready, 1);
    check("sim_data_inst_ready", bus.inst_ready, 0);
    cyc();
    man_ready = 1'b0; bus.data_en = 1'b0;
    smp();
    check("sim_idle", bus.mem_en, 0);

    // Fairness: both held, memory always ready -> strict I,D alternation
    cyc(); srst = 1'b1;
    cyc(); srst = 1'b0;
    bus.inst_en = 1'b1; bus.inst_addr = 16'h0030;
    bus.data_en = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 16'h0140; bus.data_strb = 4'h0;
    n_i = 0;
    n_d = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      man_ready = 1'b1;
      if (k == 7) bus.inst_en = 1'b0;
      smp();
      exp_i = (k % 2 == 0);
      check("fair_inst_ready", bus.inst_ready, exp_i);
      check("fair_data_ready", bus.data_ready, !exp_i);
      n_i += int'(bus.inst_ready);
      n_d += int'(bus.data_ready);
    end
    cyc();
    man_ready = 1'b0; bus.data_en = 1'b0;
    smp();
    check("fair_inst_count", n_i, 4);
    check("fair_data_count", n_d, 4);
    check("fair_idle", bus.mem_en, 0);

    // Stray ready while idle
    for (int k = 0; k < 3; k++) begin
      cyc();
      man_ready = 1'b1;
      smp();
      check("stray_inst_ready", bus.inst_ready, 0);
      check("stray_data_ready", bus.data_ready, 0);
      check("stray_mem_en", bus.mem_en, 0);
    end
    cyc();
    man_ready = 1'b0;

    // Randomized traffic against the reference model
    cyc();
    mem_auto = 1'b1;
    sb_en    = 1'b1;
    fork
      fetch_driver(60);
      data_driver(60);
    join
    repeat (4) cyc();
    sb_en    = 1'b0;
    mem_auto = 1'b0;
    check("rand_inst_q_drained", exp_inst_q.size(), 0);
    check("rand_data_q_drained", exp_data_q.size(), 0);
    check("rand_no_err", err, 0);

    // Watchdog: ready withheld 10 cycles, err after the 4th stalled cycle
    cyc();
    bus.inst_en = 1'b1; bus.inst_addr = 16'h0040;
    for (int k = 1; k <= 10; k++) begin
      cyc(); smp();
      if (k == 4) check("to_err_before", err, 0);
      if (k == 5) check("to_err_set", err, 1);
      if (k == 10) check("to_still_granted", bus.mem_en, 1);
    end
    cyc();
    man_ready = 1'b1; man_rdata = 32'h1234_5678;
    smp();
    check("to_late_ready", bus.inst_ready, 1);
    check("to_late_rdata", bus.inst_rdata, 32'h1234_5678);
    check("to_err_held", err, 1);
    cyc();
    man_ready = 1'b0; man_rdata = '0; bus.inst_en = 1'b0;
    smp();
    check("to_err_sticky", err, 1);
    check("to_idle", bus.mem_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
